batch_io: RTL and testbench

Host-side endpoint of the batch accelerator's stream interface, the opposite end of the batch controller's src/dst ports. It streams weights from a source memory with `matw` high, then streams input samples with `run` high, and marks the final batch with `last`. It accepts the result stream (`dst_valid`/`dst_last`/`dst_ready`) into a result memory. It sits between the DMA-loaded buffers and the batch controller, and reports completion and framing errors to the control registers.

---
 rtl/batch_io_pkg.sv | 14 +
 rtl/batch_io_rd_skid2.sv | 53 +++++
 rtl/batch_io.sv | 182 ++++++++++++++++++
 tb/tb_batch_io.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/batch_io_pkg.sv
// Shared types and constants for the batch accelerator host-side stream endpoint.
package batch_io_pkg;
    localparam int DW_DEF    = 32;
    localparam int MAW_DEF   = 16;
    localparam int SRC_TOT_W = 18;

    typedef enum logic [2:0] {S_IDLE, S_PARAM, S_GAP, S_RUN, S_DONE} state_t;

    // (n_batch+1)*(src_len+1); the largest job is 256*512, which fits in 18 bits
    function automatic logic [SRC_TOT_W-1:0] src_total(input logic [7:0] n_batch,
                                                       input logic [8:0] src_len);
        return ({10'd0, n_batch} + 18'd1) * ({9'd0, src_len} + 18'd1);
    endfunction
endpackage

// File: rtl/batch_io_rd_skid2.sv
// Two-entry read-data skid FIFO for a memory with one cycle of read latency.
// It also decides when a new read may be issued without overflowing.
module rd_skid2 #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          rd_en,
    input  logic          pop,
    input  logic [DW-1:0] rd_data,
    output logic          issue,
    output logic          empty,
    output logic [DW-1:0] head
);
    logic [1:0][DW-1:0] mem_q, mem_d;
    logic               wp_q, wp_d, rp_q, rp_d, infl_q, infl_d;
    logic [1:0]         occ_q, occ_d;
    logic [2:0]         level;

    always_comb begin
        // A read is allowed only if its data is guaranteed a free slot on return
        level  = {1'b0, occ_q} + {2'b0, infl_q} - {2'b0, pop};
        issue  = rd_en && (level < 3'd2);
        empty  = (occ_q == 2'd0);
        head   = mem_q[rp_q];
        mem_d  = mem_q;
        wp_d   = wp_q;
        rp_d   = rp_q;
        infl_d = issue;
        occ_d  = occ_q + {1'b0, infl_q} - {1'b0, pop};
        if (infl_q) begin
            mem_d[wp_q] = rd_data;
            wp_d        = ~wp_q;
        end
        if (pop) rp_d = ~rp_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_q  <= '0;
            wp_q   <= 1'b0;
            rp_q   <= 1'b0;
            infl_q <= 1'b0;
            occ_q  <= 2'd0;
        end else begin
            mem_q  <= mem_d;
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            infl_q <= infl_d;
            occ_q  <= occ_d;
        end
    end
endmodule

// File: rtl/batch_io.sv
// Host-side stream endpoint: streams weights then batch samples from source memory,
// and writes the result stream into result memory while checking its framing.
module batch_io
    import batch_io_pkg::*;
#(
    parameter int DW  = DW_DEF,
    parameter int MAW = MAW_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [9:0]     prm_len,
    input  logic [8:0]     src_len,
    input  logic [8:0]     dst_len,
    input  logic [7:0]     n_batch,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic           matw,
    output logic           run,
    output logic           last,
    output logic           src_valid,
    output logic [DW-1:0]  src_data,
    input  logic           src_ready,
    output logic           sm_rd,
    output logic [MAW-1:0] sm_a,
    input  logic [DW-1:0]  sm_q,
    input  logic           dst_valid,
    input  logic           dst_last,
    input  logic [DW-1:0]  dst_data,
    output logic           dst_ready,
    input  logic           rm_hold,
    output logic           rm_we,
    output logic [MAW-1:0] rm_a,
    output logic [DW-1:0]  rm_d
);
    state_t                 state_q, state_d;
    logic [SRC_TOT_W-1:0]   tot_q, tot_d, rd_rem_q, rd_rem_d, xfer_rem_q, xfer_rem_d;
    logic [MAW-1:0]         sm_a_q, sm_a_d, rm_a_q, rm_a_d;
    logic [8:0]             dst_len_q, dst_len_d, bcnt_q, bcnt_d;
    logic [7:0]             n_batch_q, n_batch_d, dbat_q, dbat_d;
    logic                   err_q, err_d, last_q, last_d, res_done_q, res_done_d;
    logic                   st_param, st_run, rd_en, pop, acc, fifo_empty;
    logic                   src_fin, fin_dst;
    logic [DW-1:0]          head;

    assign st_param  = (state_q == S_PARAM);
    assign st_run    = (state_q == S_RUN);
    assign rd_en     = (st_param || st_run) && (rd_rem_q != '0);
    assign src_valid = !fifo_empty && (st_param || st_run);
    // Weights load on valid alone; ready only matters in the data phase
    assign pop       = src_valid && (st_param || src_ready);
    assign src_data  = src_valid ? head : '0;
    assign sm_a      = sm_a_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign matw      = st_param;
    assign run       = st_run || done;
    assign last      = last_q;
    assign err       = err_q;
    assign dst_ready = run && !rm_hold;
    assign acc       = dst_valid && dst_ready;
    assign rm_we     = acc;
    assign rm_a      = rm_a_q;
    assign rm_d      = acc ? dst_data : '0;

    rd_skid2 #(.DW(DW)) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .rd_en   (rd_en),
        .pop     (pop),
        .rd_data (sm_q),
        .issue   (sm_rd),
        .empty   (fifo_empty),
        .head    (head)
    );

    always_comb begin
        state_d    = state_q;
        tot_d      = tot_q;
        rd_rem_d   = rd_rem_q;
        xfer_rem_d = xfer_rem_q;
        sm_a_d     = sm_a_q;
        rm_a_d     = rm_a_q;
        dst_len_d  = dst_len_q;
        bcnt_d     = bcnt_q;
        n_batch_d  = n_batch_q;
        dbat_d     = dbat_q;
        err_d      = err_q;
        last_d     = last_q;
        res_done_d = res_done_q;

        if (sm_rd) begin
            rd_rem_d = rd_rem_q - 18'd1;
            sm_a_d   = sm_a_q + MAW'(1);
        end
        if (pop) xfer_rem_d = xfer_rem_q - 18'd1;
        src_fin = st_run && pop && (xfer_rem_q == 18'd1);
        if (src_fin) last_d = 1'b1;

        fin_dst = st_run && acc && dst_last && (dbat_q == n_batch_q) && !res_done_q;
        if (acc) begin
            rm_a_d = rm_a_q + MAW'(1);
            if (dst_last) begin
                if (bcnt_q != dst_len_q) err_d = 1'b1;
                bcnt_d = 9'd0;
                dbat_d = dbat_q + 8'd1;
            end else begin
                if (bcnt_q == dst_len_q) err_d = 1'b1;
                bcnt_d = bcnt_q + 9'd1;
            end
        end
        // Final result arriving while source beats are still owed is a framing error
        if (fin_dst && !(last_q || src_fin)) err_d = 1'b1;

        case (state_q)
            S_IDLE: if (start) begin
                err_d      = 1'b0;
                last_d     = 1'b0;
                res_done_d = 1'b0;
                sm_a_d     = '0;
                rm_a_d     = '0;
                bcnt_d     = 9'd0;
                dbat_d     = 8'd0;
                tot_d      = src_total(n_batch, src_len);
                dst_len_d  = dst_len;
                n_batch_d  = n_batch;
                rd_rem_d   = {8'd0, prm_len};
                xfer_rem_d = {8'd0, prm_len};
                state_d    = (prm_len != 10'd0) ? S_PARAM : S_GAP;
            end
            S_PARAM: if (pop && (xfer_rem_q == 18'd1)) state_d = S_GAP;
            S_GAP: begin
                rd_rem_d   = tot_q;
                xfer_rem_d = tot_q;
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (fin_dst) res_done_d = 1'b1;
                if ((res_done_q || fin_dst) && (last_q || src_fin)) state_d = S_DONE;
            end
            S_DONE: begin
                last_d     = 1'b0;
                res_done_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            tot_q      <= '0;
            rd_rem_q   <= '0;
            xfer_rem_q <= '0;
            sm_a_q     <= '0;
            rm_a_q     <= '0;
            dst_len_q  <= '0;
            bcnt_q     <= '0;
            n_batch_q  <= '0;
            dbat_q     <= '0;
            err_q      <= 1'b0;
            last_q     <= 1'b0;
            res_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tot_q      <= tot_d;
            rd_rem_q   <= rd_rem_d;
            xfer_rem_q <= xfer_rem_d;
            sm_a_q     <= sm_a_d;
            rm_a_q     <= rm_a_d;
            dst_len_q  <= dst_len_d;
            bcnt_q     <= bcnt_d;
            n_batch_q  <= n_batch_d;
            dbat_q     <= dbat_d;
            err_q      <= err_d;
            last_q     <= last_d;
            res_done_q <= res_done_d;
        end
    end
endmodule

// File: tb/tb_batch_io.sv
// Self-checking bench for batch_io: directed jobs plus randomized jobs against a
// memory-content / result-stream reference model.
module tb_batch_io;
    localparam int DW  = 32;
    localparam int MAW = 16;

    logic           clk = 1'b0, reset_n = 1'b0, start = 1'b0;
    logic [9:0]     prm_len = '0;
    logic [8:0]     src_len = '0, dst_len = '0;
    logic [7:0]     n_batch = '0;
    logic           busy, done, err, matw, run, last, src_valid, sm_rd, dst_ready, rm_we;
    logic [DW-1:0]  src_data, sm_q, rm_d;
    logic [MAW-1:0] sm_a, rm_a;
    logic           src_ready = 1'b0, dst_valid = 1'b0, dst_last = 1'b0, rm_hold = 1'b0;
    logic [DW-1:0]  dst_data = '0;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    batch_io #(.DW(DW), .MAW(MAW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .prm_len(prm_len), .src_len(src_len),
        .dst_len(dst_len), .n_batch(n_batch), .busy(busy), .done(done), .err(err),
        .matw(matw), .run(run), .last(last), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .sm_rd(sm_rd), .sm_a(sm_a), .sm_q(sm_q),
        .dst_valid(dst_valid), .dst_last(dst_last), .dst_data(dst_data),
        .dst_ready(dst_ready), .rm_hold(rm_hold), .rm_we(rm_we), .rm_a(rm_a), .rm_d(rm_d)
    );

    function automatic logic [DW-1:0] mem_f(input logic [MAW-1:0] a);
        return {a, ~a} ^ 32'h3C5A_96E1;
    endfunction

    // Source memory with one cycle read latency
    always @(posedge clk) sm_q <= sm_rd ? mem_f(sm_a) : 32'hBAD0_BAD0;

    typedef struct packed { logic lst; logic [DW-1:0] d; } beat_t;
    beat_t          dq[$];
    logic [DW-1:0]  obs_src[$], obs_rmd[$];
    logic           obs_ph[$];
    logic [MAW-1:0] obs_sma[$], obs_rma[$];
    int  first_rd, run_rise, last_rise, fin_src_cyc, wlast_cyc, data_first, data_lastc, first_wr;
    int  done_cnt, hold_viol, matw_cnt, post_done_bad, hold_seen, hold_bad;
    int  src_bad, sma_bad, wr_bad;
    logic exp_early, exp_err, job_err, err_c1, timed_out;

    task automatic make_results(input int nb, input int dl, input bit bad);
        dq.delete();
        for (int b = 0; b <= nb; b++) begin
            int n = (bad && b == 0) ? 1 : dl + 1;
            for (int k = 0; k < n; k++) begin
                beat_t bt;
                bt.lst = (k == n - 1);
                bt.d   = $urandom;
                dq.push_back(bt);
            end
        end
    endtask

    // Result framing rule: dst_last exactly on beat dst_len of each batch
    function automatic logic frame_err(input int dl);
        int pos = 0;
        logic e = 1'b0;
        foreach (dq[i]) begin
            if (dq[i].lst) begin
                if (pos != dl) e = 1'b1;
                pos = 0;
            end else begin
                if (pos == dl) e = 1'b1;
                pos++;
            end
        end
        return e;
    endfunction

    // rdy_mode: 0 always, 1 toggle, 2 random; hold_mode: 0 none, 1 five cycles, 2 random
    task automatic run_job(input int prm, input int sl, input int dl, input int nb,
                           input int rdy_mode, input int hold_mode, input bit pace,
                           input bit restart, input int abort_cyc);
        int tot = (nb + 1) * (sl + 1);
        int nres = dq.size();
        int ridx = 0, cyc = 0, src_n = 0, done_at = -1;
        logic prev_stall = 1'b0;
        logic [DW-1:0] stall_d = '0;
        obs_src.delete(); obs_ph.delete(); obs_sma.delete(); obs_rma.delete(); obs_rmd.delete();
        first_rd = -1; run_rise = -1; last_rise = -1; fin_src_cyc = -1; wlast_cyc = -1;
        data_first = -1; data_lastc = -1; first_wr = -1;
        done_cnt = 0; hold_viol = 0; matw_cnt = 0; post_done_bad = 0; hold_seen = 0; hold_bad = 0;
        exp_early = 1'b0; timed_out = 1'b0; job_err = 1'b0; err_c1 = 1'b1;
        prm_len = 10'(prm); src_len = 9'(sl); dst_len = 9'(dl); n_batch = 8'(nb);
        forever begin
            @(posedge clk); #1;
            if (abort_cyc > 0 && cyc == abort_cyc) return;
            start = (cyc == 0) || (restart && cyc >= 3 && cyc <= 6);
            case (rdy_mode)
                0:       src_ready = 1'b1;
                1:       src_ready = (cyc % 2 == 0);
                default: src_ready = ($urandom % 4 != 0);
            endcase
            case (hold_mode)
                1:       rm_hold = (first_wr >= 0 && cyc > first_wr && cyc <= first_wr + 5);
                2:       rm_hold = ($urandom % 8 == 0);
                default: rm_hold = 1'b0;
            endcase
            if (ridx < nres && !(pace && ridx == nres - 1 && src_n < prm + tot)
                && (rdy_mode == 0 || $urandom % 4 != 0)) begin
                dst_valid = 1'b1; dst_last = dq[ridx].lst; dst_data = dq[ridx].d;
            end else begin
                dst_valid = 1'b0; dst_last = 1'($urandom); dst_data = $urandom;
            end
            @(negedge clk);
            if (cyc == 1) err_c1 = err;
            if (sm_rd) begin
                if (first_rd < 0) first_rd = cyc;
                obs_sma.push_back(sm_a);
            end
            if (matw) matw_cnt++;
            if (run && run_rise < 0) run_rise = cyc;
            if (last && last_rise < 0) last_rise = cyc;
            if (prev_stall && (!src_valid || src_data !== stall_d)) hold_viol++;
            prev_stall = src_valid && run && !src_ready;
            stall_d    = src_data;
            if (src_valid && (matw || (run && src_ready))) begin
                obs_src.push_back(src_data); obs_ph.push_back(matw); src_n++;
                if (matw) wlast_cyc = cyc;
                else begin
                    if (data_first < 0) data_first = cyc;
                    data_lastc = cyc;
                end
                if (src_n == prm + tot) fin_src_cyc = cyc;
            end
            if (hold_mode == 1 && rm_hold) begin
                hold_seen++;
                if (dst_ready || rm_we) hold_bad++;
            end
            if (rm_we) begin
                if (first_wr < 0) first_wr = cyc;
                obs_rma.push_back(rm_a); obs_rmd.push_back(rm_d);
            end
            if (dst_valid && dst_ready) begin
                if (ridx == nres - 1 && src_n < prm + tot) exp_early = 1'b1;
                ridx++;
            end
            if (done) begin
                done_cnt++; done_at = cyc; job_err = err;
            end
            if (done_at >= 0 && cyc == done_at + 1) begin
                if (busy || run || last || done) post_done_bad++;
                break;
            end
            cyc++;
            if (cyc > 4000) begin
                timed_out = 1'b1;
                break;
            end
        end
        start = 1'b0; dst_valid = 1'b0; rm_hold = 1'b0;
        src_bad = 0; sma_bad = 0; wr_bad = 0;
        if (obs_src.size() != prm + tot) src_bad++;
        else for (int i = 0; i < prm + tot; i++)
            if (obs_src[i] !== mem_f(i[MAW-1:0]) || obs_ph[i] !== (i < prm)) src_bad++;
        if (obs_sma.size() != prm + tot) sma_bad++;
        else for (int i = 0; i < prm + tot; i++)
            if (obs_sma[i] !== i[MAW-1:0]) sma_bad++;
        if (obs_rma.size() != nres) wr_bad++;
        else for (int i = 0; i < nres; i++)
            if (obs_rma[i] !== i[MAW-1:0] || obs_rmd[i] !== dq[i].d) wr_bad++;
        exp_err = frame_err(dl) | exp_early;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b1; src_ready = 1'b1; dst_valid = 1'b1; dst_data = $urandom;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, err, matw, run, last, src_valid, sm_rd, dst_ready, rm_we} !== 10'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0", {busy, done, err, matw, run, last, src_valid, sm_rd, dst_ready, rm_we});
        end
        checks++;
        if ({src_data, sm_a, rm_a, rm_d} !== 96'd0) begin
            failures++;
            $display("FAIL reset_bus src_data=%h sm_a=%h rm_a=%h rm_d=%h want=0", src_data, sm_a, rm_a, rm_d);
        end
        start = 1'b0; dst_valid = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
    endtask

    task automatic test_basic;
        make_results(1, 1, 1'b0);
        run_job(4, 3, 1, 1, 0, 0, 1'b1, 1'b0, 0);
        checks++; if (timed_out) begin failures++; $display("FAIL basic_timeout got=1 want=0"); end
        checks++; if (src_bad !== 0) begin failures++; $display("FAIL basic_src bad=%0d want=0", src_bad); end
        checks++; if (sma_bad !== 0) begin failures++; $display("FAIL basic_sm_a bad=%0d want=0", sma_bad); end
        checks++; if (wr_bad !== 0) begin failures++; $display("FAIL basic_rm bad=%0d want=0", wr_bad); end
        checks++; if (first_rd !== 1) begin failures++; $display("FAIL basic_first_rd got=%0d want=1", first_rd); end
        checks++; if (run_rise !== wlast_cyc + 2) begin failures++; $display("FAIL basic_gap run=%0d want=%0d", run_rise, wlast_cyc + 2); end
        checks++; if (data_lastc - data_first !== 7) begin failures++; $display("FAIL basic_thru span=%0d want=7", data_lastc - data_first); end
        checks++; if (last_rise !== fin_src_cyc + 1) begin failures++; $display("FAIL basic_last got=%0d want=%0d", last_rise, fin_src_cyc + 1); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done got=%0d want=1", done_cnt); end
        checks++; if (post_done_bad !== 0) begin failures++; $display("FAIL basic_post_done got=%0d want=0", post_done_bad); end
        checks++; if (job_err !== exp_err) begin failures++; $display("FAIL basic_err got=%b want=%b", job_err, exp_err); end
    endtask

    task automatic test_stall;
        make_results(1, 1, 1'b0);
        run_job(4, 3, 1, 1, 1, 0, 1'b1, 1'b0, 0);
        checks++; if (src_bad !== 0) begin failures++; $display("FAIL stall_src bad=%0d want=0", src_bad); end
        checks++; if (hold_viol !== 0) begin failures++; $display("FAIL stall_hold viol=%0d want=0", hold_viol); end
        checks++; if (wr_bad !== 0) begin failures++; $display("FAIL stall_rm bad=%0d want=0", wr_bad); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL stall_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_no_param;
        make_results(1, 1, 1'b0);
        run_job(0, 3, 1, 1, 0, 0, 1'b1, 1'b0, 0);
        checks++; if (matw_cnt !== 0) begin failures++; $display("FAIL noprm_matw got=%0d want=0", matw_cnt); end
        checks++; if (run_rise !== 2) begin failures++; $display("FAIL noprm_run got=%0d want=2", run_rise); end
        checks++; if (src_bad !== 0) begin failures++; $display("FAIL noprm_src bad=%0d want=0", src_bad); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL noprm_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_err;
        make_results(1, 1, 1'b1);
        run_job(2, 3, 1, 1, 0, 0, 1'b1, 1'b0, 0);
        checks++; if (job_err !== 1'b1 || exp_err !== 1'b1) begin failures++; $display("FAIL err_set got=%b want=%b", job_err, exp_err); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL err_done got=%0d want=1", done_cnt); end
        checks++; if (wr_bad !== 0) begin failures++; $display("FAIL err_rm bad=%0d want=0", wr_bad); end
        make_results(1, 1, 1'b0);
        run_job(2, 3, 1, 1, 0, 0, 1'b1, 1'b0, 0);
        checks++; if (err_c1 !== 1'b0) begin failures++; $display("FAIL err_clear got=%b want=0", err_c1); end
        checks++; if (job_err !== 1'b0) begin failures++; $display("FAIL err_clean got=%b want=0", job_err); end
    endtask

    task automatic test_hold;
        make_results(1, 1, 1'b0);
        run_job(4, 3, 1, 1, 0, 1, 1'b1, 1'b0, 0);
        checks++; if (hold_seen !== 5) begin failures++; $display("FAIL hold_cycles got=%0d want=5", hold_seen); end
        checks++; if (hold_bad !== 0) begin failures++; $display("FAIL hold_ready got=%0d want=0", hold_bad); end
        checks++; if (wr_bad !== 0) begin failures++; $display("FAIL hold_rm bad=%0d want=0", wr_bad); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL hold_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_reset_mid;
        int dn = 0;
        make_results(1, 1, 1'b0);
        run_job(4, 3, 1, 1, 0, 0, 1'b1, 1'b0, 12);
        checks++; if (run !== 1'b1) begin failures++; $display("FAIL rstmid_inrun got=%b want=1", run); end
        reset_n = 1'b0; src_ready = 1'b1; dst_valid = 1'b1; dst_data = $urandom;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, err, matw, run, last, src_valid, sm_rd, dst_ready, rm_we} !== 10'b0
            || {src_data, sm_a, rm_a, rm_d} !== 96'd0) begin
            failures++;
            $display("FAIL rstmid_zero ctrl=%b sm_a=%h rm_a=%h want=0",
                     {busy, done, err, matw, run, last, src_valid, sm_rd, dst_ready, rm_we}, sm_a, rm_a);
        end
        reset_n = 1'b1; dst_valid = 1'b0;
        repeat (4) begin @(negedge clk); if (done) dn++; end
        checks++; if (dn !== 0) begin failures++; $display("FAIL rstmid_nodone got=%0d want=0", dn); end
        make_results(1, 1, 1'b0);
        run_job(4, 3, 1, 1, 0, 0, 1'b1, 1'b0, 0);
        checks++; if (sma_bad !== 0) begin failures++; $display("FAIL rstmid_sm_a bad=%0d want=0", sma_bad); end
        checks++; if (src_bad !== 0) begin failures++; $display("FAIL rstmid_src bad=%0d want=0", src_bad); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rstmid_done got=%0d want=1", done_cnt); end
    endtask

    task automatic test_random;
        for (int j = 0; j < 6; j++) begin
            int prm = $urandom_range(0, 8), sl = $urandom_range(3, 15);
            int nb = $urandom_range(1, 3), dl = $urandom_range(0, 3);
            bit pace = 1'($urandom);
            make_results(nb, dl, 1'b0);
            run_job(prm, sl, dl, nb, 2, 2, pace, 1'b1, 0);
            checks++; if (timed_out) begin failures++; $display("FAIL rnd%0d_timeout got=1 want=0", j); end
            checks++; if (src_bad !== 0) begin failures++; $display("FAIL rnd%0d_src bad=%0d want=0", j, src_bad); end
            checks++; if (sma_bad !== 0) begin failures++; $display("FAIL rnd%0d_sm_a bad=%0d want=0", j, sma_bad); end
            checks++; if (wr_bad !== 0) begin failures++; $display("FAIL rnd%0d_rm bad=%0d want=0", j, wr_bad); end
            checks++; if (job_err !== exp_err) begin failures++; $display("FAIL rnd%0d_err got=%b want=%b", j, job_err, exp_err); end
            checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rnd%0d_done got=%0d want=1", j, done_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_no_param();
        test_err();
        test_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
